// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive sides.
package uart_pkg;

  localparam int unsigned UART_DATA_W  = 8;
  localparam int unsigned UART_TIMER_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Cycles per bit; TX and RX both derive their timing from this.
  function automatic int unsigned uart_bit_period(input int unsigned clock_freq,
                                                  input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the data source and the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   tx_busy;
  logic                   tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit timer: 16-bit down-counter issuing a one-cycle tick every BIT_PERIOD
// cycles after restart. Reusable by the receiver.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [UART_TIMER_W-1:0] RELOAD = UART_TIMER_W'(BIT_PERIOD - 1);

  logic [UART_TIMER_W-1:0] cnt_q;
  logic [UART_TIMER_W-1:0] cnt_d;

  // Reload on restart or when the current bit period has elapsed.
  always_comb begin
    cnt_d = cnt_q - UART_TIMER_W'(1);
    if (restart || (cnt_q == '0)) begin
      cnt_d = RELOAD;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per handshake as an 8N1 frame, LSB first.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLOCK_FREQ = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_tx_if.slave    tx_if,
  output logic        tx
);

  localparam int unsigned BIT_PERIOD = uart_bit_period(CLOCK_FREQ, BAUD_RATE);

  if ((BIT_PERIOD < 2) || (BIT_PERIOD > 65535)) begin : g_bad_period
    $error("uart_tx: BIT_PERIOD out of range 2..65535");
  end

  uart_tx_state_t         state_q, state_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]             idx_q,   idx_d;
  logic                   tx_q,    tx_d;
  logic                   done_q,  done_d;
`ifdef UART_TX_PARITY_EN
  logic                   par_q,   par_d;
`endif

  logic accept;
  logic tick;

  assign accept = tx_if.tx_valid && (state_q == IDLE);

  uart_baud_gen #(
    .BIT_PERIOD (BIT_PERIOD)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .tick    (tick)
  );

  // Next-state logic; tx_d is the line value for the state being entered,
  // so the line comes straight from a flop.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = START;
          shreg_d = tx_if.tx_data;
          idx_d   = '0;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_if.tx_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shreg_d = {1'b0, shreg_q[UART_DATA_W-1:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx             = tx_q;
  assign tx_if.tx_ready = (state_q == IDLE);
  assign tx_if.tx_busy  = (state_q != IDLE);
  assign tx_if.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLOCK_FREQ=160, BAUD_RATE=10 (16 cycles/bit).
module tb_uart_tx;

  localparam int unsigned P = 16;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned F = NBITS * P;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic tx;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  uart_tx_if bus ();

  uart_tx #(
    .BAUD_RATE  (10),
    .CLOCK_FREQ (160)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx_if (bus),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected line level in cycle c (1-based) after the acceptance edge.
  function automatic logic exp_bit(input logic [7:0] d, input int unsigned c);
    int unsigned b;
    b = (c - 1) / P;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic start_byte(input logic [7:0] d);
    @(negedge clk);
    check_eq("ready_before_send", {31'b0, bus.tx_ready}, 32'd1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(posedge clk);
  endtask

  // Follows the line for cycles 1..last; when last==F also checks the done cycle.
  task automatic watch_frame(input string tag, input logic [7:0] d,
                             input int unsigned last, input bit drop_valid);
    for (int unsigned c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1 && drop_valid) bus.tx_valid = 1'b0;
      check_eq($sformatf("%s_tx_c%0d", tag, c), {31'b0, tx}, {31'b0, exp_bit(d, c)});
      if (c == 1 || c == last) begin
        check_eq($sformatf("%s_ready_c%0d", tag, c), {31'b0, bus.tx_ready}, 32'd0);
        check_eq($sformatf("%s_busy_c%0d", tag, c), {31'b0, bus.tx_busy}, 32'd1);
        check_eq($sformatf("%s_done_c%0d", tag, c), {31'b0, bus.tx_done}, 32'd0);
      end
    end
    if (last == F) begin
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, {31'b0, bus.tx_done}, 32'd1);
      check_eq({tag, "_done_ready"}, {31'b0, bus.tx_ready}, 32'd1);
      check_eq({tag, "_done_tx"}, {31'b0, tx}, 32'd1);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_tx"}, {31'b0, tx}, 32'd1);
    check_eq({tag, "_ready"}, {31'b0, bus.tx_ready}, 32'd1);
    check_eq({tag, "_busy"}, {31'b0, bus.tx_busy}, 32'd0);
    check_eq({tag, "_done"}, {31'b0, bus.tx_done}, 32'd0);
  endtask

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("post_reset");

    // 1: single byte 0x55
    start_byte(8'h55);
    watch_frame("t1", 8'h55, F, 1'b1);
    @(negedge clk);
    check_idle("t1_after");

    // 2: data change and valid pulse mid-frame are ignored
    start_byte(8'hA3);
    fork
      watch_frame("t2", 8'hA3, F, 1'b1);
      begin
        repeat (40) @(negedge clk);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        repeat (20) @(negedge clk);
        bus.tx_valid = 1'b0;
      end
    join
    @(negedge clk);
    check_idle("t2_after");
    repeat (20) @(negedge clk);
    check_idle("t2_later");

    // 3: back-to-back with valid held; second accepted in the done cycle
    start_byte(8'h00);
    fork
      watch_frame("t3a", 8'h00, F, 1'b0);
      begin
        repeat (F) @(negedge clk);
        bus.tx_data = 8'hFF;
      end
    join
    watch_frame("t3b", 8'hFF, F, 1'b1);
    @(negedge clk);
    check_idle("t3_after");

    // 4: asynchronous reset during data bit 3 of 0x0F
    start_byte(8'h0F);
    watch_frame("t4", 8'h0F, 70, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_idle("t4_async_reset");
    repeat (2) @(negedge clk);
    check_idle("t4_in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("t4_released");
    start_byte(8'h81);
    watch_frame("t4b", 8'h81, F, 1'b1);
    @(negedge clk);
    check_idle("t4b_after");

`ifdef UART_TX_PARITY_EN
    // 5: even parity bit
    start_byte(8'h07);
    watch_frame("t5a", 8'h07, F, 1'b1);
    start_byte(8'h03);
    watch_frame("t5b", 8'h03, F, 1'b1);
    @(negedge clk);
    check_idle("t5_after");
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one byte per handshake onto the `tx` line as an 8N1 frame (start bit, 8 data bits LSB first, stop bit), with optional even parity. It is the transmit counterpart to `uart_rx` and shares its `CLOCK_FREQ`/`BAUD_RATE` parameters and bit-period arithmetic, so both ends of a link are configured identically. It sits between the FPU result path and the board's serial TX pin.

## Interface
- `BAUD_RATE`, 9600: line rate in bits/s.
- `CLOCK_FREQ`, 100000000: `clk` frequency in Hz.
- Derived constant `BIT_PERIOD` = `CLOCK_FREQ / BAUD_RATE` (integer division), giving 10416 cycles at the defaults. It must satisfy 2 ≤ `BIT_PERIOD` ≤ 65535.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tx_data`  in  8  byte to send; sampled only on acceptance.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  high when a new byte can be accepted (state IDLE).
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  high while a frame is on the line (`!tx_ready`).
- `tx_done`  out  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- **Acceptance:** a byte is accepted on a rising `clk` edge where `tx_valid && tx_ready` is true. `tx_data` is latched into the shift register on that edge. Later changes to `tx_data` have no effect.
- **While busy:** `tx_valid` is ignored. There is no queue, and the request must be held until `tx_ready` returns.
- **State machine:** IDLE → START → DATA → [PARITY] → STOP → IDLE. All states are registered.
  - IDLE: `tx`=1, `tx_ready`=1. Leaves on acceptance.
  - START: `tx`=0 for `BIT_PERIOD` cycles.
  - DATA: `tx` = shift-register bit 0 for `BIT_PERIOD` cycles per bit. The register shifts right at each bit boundary. A 3-bit index counts 0..7, and the state exits after bit 7.
  - PARITY (only when the configuration macro is defined): `tx` = XOR of the latched byte, i.e. even parity. Lasts `BIT_PERIOD` cycles.
  - STOP: `tx`=1 for `BIT_PERIOD` cycles, then return to IDLE.
- **Bit timer:** 16-bit down-counter.
  - Loaded with `BIT_PERIOD-1` on acceptance and at each bit boundary.
  - A bit boundary occurs when the counter reaches 0.
  - No wrap-around is possible, because the reload value always fits in 16 bits.
- **`tx` register:** `tx` is driven from a flop, not decoded combinationally, so the line never glitches.
- **Reset:** on reset, and on reset asserted mid-frame, everything clears immediately and asynchronously:
  - state = IDLE, `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0;
  - timer, index and shift register = 0.
  - An abandoned frame is not resumed. The far-end receiver sees a truncated frame, which fails its stop check.

## Timing
- **Acceptance at edge N:** `tx` falls (start bit) in the cycle after edge N, and `tx_ready` is low from that same cycle.
- **Frame occupancy:** F = 10·`BIT_PERIOD` cycles, or 11·`BIT_PERIOD` with parity.
- **End of frame:** `tx_done` is high for exactly one cycle, the first IDLE cycle after STOP. `tx_ready` is high in that same cycle.
- **Back-to-back bytes:** acceptance is permitted in the `tx_done` cycle. The stop bit is then effectively `BIT_PERIOD`+1 cycles long, and the minimum spacing between acceptances is F+1 cycles.
- **Simultaneous events:** if `tx_valid` is high in the `tx_done` cycle, the byte is accepted and `tx_done` still pulses.

## Configuration
- **`UART_TX_PARITY_EN` defined:** the PARITY state is compiled in, giving a 9-bit payload frame of 11·`BIT_PERIOD` cycles with an even-parity bit between bit 7 and stop.
- **`UART_TX_PARITY_EN` undefined:** the PARITY state and XOR logic are absent, giving a strict 8N1 frame of 10·`BIT_PERIOD` cycles.
- **Pairing:** a matching receiver must be built with the same setting.

## Structure
- **Package `uart_pkg`:**
  - state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_W`=8;
  - `UART_TIMER_W`=16;
  - a function computing `BIT_PERIOD` from `CLOCK_FREQ`/`BAUD_RATE`, so the TX and RX sides derive it identically.
- **Sub-module `uart_baud_gen`:** the bit-timer counter. Ports: `clk`, `rst_n`, `restart`, `tick`. It issues a one-cycle `tick` every `BIT_PERIOD` cycles after `restart`, and can be reused by the receiver later.

## Test plan
Bench parameters are `CLOCK_FREQ`=160 and `BAUD_RATE`=10, giving `BIT_PERIOD`=16, unless stated otherwise.
1. **Single byte:** reset, then accept 0x55 at edge 0. `tx` is low for cycles 1–16, then alternates 1,0,1,0,1,0,1,0 in 16-cycle bits, then high for 145–160. `tx_done` pulses at cycle 161, with `tx_ready`=1 in the same cycle.
2. **Hold and ignore:** accept 0xA3, then change `tx_data` to 0xFF and pulse `tx_valid` mid-frame. The line still carries 0xA3 (LSB first 1,1,0,0,0,1,0,1), and only one `tx_done` occurs.
3. **Back-to-back:** hold `tx_valid` high with 0x00 then 0xFF. Acceptances are exactly 161 cycles apart, and the second start bit follows a 17-cycle stop bit.
4. **Reset mid-frame:** assert `rst_n`=0 during data bit 3 of 0x0F. `tx`=1, `tx_ready`=1 and `tx_done`=0 take effect immediately. After release, a new byte 0x81 is sent correctly.
5. **Parity (`UART_TX_PARITY_EN`):** send 0x07, which has three ones, so the parity bit is 1. Send 0x03, so the parity bit is 0. `tx_done` arrives at cycle 177.
6. **Loopback:** with default parameters, tie `tx` to `uart_rx.rx` and send 0xA5, 0x3C. The receiver reports 0xA5 then 0x3C with `rx_done` pulses.
